// File: rtl/RS5_pkg.sv
// ----------------------------------------------------------------------------
// Module  : RS5_pkg
// Purpose : Shared types and constants for the RTC mtimecmp reload engine.
//           Holds the reload FSM state encoding and the RTC byte addresses of
//           the mtime and mtimecmp registers.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package RS5_pkg;

  // Reload engine states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_GUARD   = 3'd4
  } reload_state_e;

  // RTC byte addresses
  localparam logic [3:0] RTC_ADDR_MTIME    = 4'h0;
  localparam logic [3:0] RTC_ADDR_MTIMECMP = 4'h8;

  // Byte-enable patterns
  localparam logic [7:0] RTC_WE_READ = 8'h00;
  localparam logic [7:0] RTC_WE_FULL = 8'hFF;

endpackage : RS5_pkg

`default_nettype wire

// File: rtl/mtimecmp_reloader.sv
// ----------------------------------------------------------------------------
// Module  : mtimecmp_reloader
// Purpose : Periodic tick generator that keeps the RTC mtimecmp register one
//           period ahead. On an enable rising edge it reads mtime (arm); while
//           enabled, each timer interrupt makes it read mtimecmp (reload). In
//           both cases it writes back read_value + period, saturating at
//           all-ones, then waits two guard cycles for the RTC compare output
//           to settle before accepting another interrupt.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           cfg_en_i            - engine enable (level)
//           period_i            - tick period in mtime counts (0 treated as 1)
//           mti_i               - registered timer-interrupt level from RTC
//           en_o/addr_o/we_o    - RTC access strobe, byte address, byte enables
//           data_o / data_i     - RTC write data / read data (1 cycle latency)
//           busy_o              - sequence in progress
//           tick_o              - one-cycle pulse per mtimecmp write
//           tick_count_o        - wrapping count of mtimecmp writes
//           sat_o               - sticky: a compare value saturated
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mtimecmp_reloader
  import RS5_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_en_i,
  input  logic [63:0] period_i,
  input  logic        mti_i,
  output logic        en_o,
  output logic [3:0]  addr_o,
  output logic [7:0]  we_o,
  output logic [63:0] data_o,
  input  logic [63:0] data_i,
  output logic        busy_o,
  output logic        tick_o,
  output logic [31:0] tick_count_o,
  output logic        sat_o
);

  reload_state_e state_q, state_d;
  logic          cfg_en_q;
  logic          src_cmp_q, src_cmp_d;     // 1: read mtimecmp (reload), 0: read mtime (arm)
  logic          guard_cnt_q, guard_cnt_d;
  logic [63:0]   next_q, next_d;
  logic          sat_q, sat_d;
  logic [31:0]   tick_count_q, tick_count_d;

  logic [63:0]   eff_period;
  logic [64:0]   sum;

  // A zero period would rewrite the same compare value and retrigger forever.
  assign eff_period = (period_i == 64'd0) ? 64'd1 : period_i;
  assign sum        = {1'b0, data_i} + {1'b0, eff_period};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cfg_en_q     <= 1'b0;
      src_cmp_q    <= 1'b0;
      guard_cnt_q  <= 1'b0;
      next_q       <= 64'd0;
      sat_q        <= 1'b0;
      tick_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cfg_en_q     <= cfg_en_i;
      src_cmp_q    <= src_cmp_d;
      guard_cnt_q  <= guard_cnt_d;
      next_q       <= next_d;
      sat_q        <= sat_d;
      tick_count_q <= tick_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_cmp_d    = src_cmp_q;
    guard_cnt_d  = guard_cnt_q;
    next_d       = next_q;
    sat_d        = sat_q;
    tick_count_d = tick_count_q;

    unique case (state_q)
      ST_IDLE: begin
        // Enable edge wins over a pending interrupt: arming re-bases on mtime.
        if (cfg_en_i && !cfg_en_q) begin
          state_d   = ST_RD_REQ;
          src_cmp_d = 1'b0;
        end else if (cfg_en_i && mti_i) begin
          state_d   = ST_RD_REQ;
          src_cmp_d = 1'b1;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        next_d  = sum[64] ? {64{1'b1}} : sum[63:0];
        sat_d   = sat_q | sum[64];
        state_d = ST_WR;
      end
      ST_WR: begin
        tick_count_d = tick_count_q + 32'd1;
        guard_cnt_d  = 1'b0;
        state_d      = ST_GUARD;
      end
      ST_GUARD: begin
        // mti_i may still reflect the old compare value for two cycles.
        if (guard_cnt_q) state_d = ST_IDLE;
        else             guard_cnt_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    en_o   = 1'b0;
    we_o   = RTC_WE_READ;
    addr_o = RTC_ADDR_MTIME;
    tick_o = 1'b0;
    if (state_q == ST_RD_REQ) begin
      en_o   = 1'b1;
      addr_o = src_cmp_q ? RTC_ADDR_MTIMECMP : RTC_ADDR_MTIME;
    end else if (state_q == ST_WR) begin
      en_o   = 1'b1;
      we_o   = RTC_WE_FULL;
      addr_o = RTC_ADDR_MTIMECMP;
      tick_o = 1'b1;
    end
  end

  assign data_o       = next_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign tick_count_o = tick_count_q;
  assign sat_o        = sat_q;

endmodule : mtimecmp_reloader

`default_nettype wire

// File: tb/tb_mtimecmp_reloader.sv
// ----------------------------------------------------------------------------
// Module  : tb_mtimecmp_reloader
// Purpose : Directed self-checking bench for mtimecmp_reloader.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mtimecmp_reloader;

  logic        clk;
  logic        reset;
  logic        cfg_en_i;
  logic [63:0] period_i;
  logic        mti_i;
  logic        en_o;
  logic [3:0]  addr_o;
  logic [7:0]  we_o;
  logic [63:0] data_o;
  logic [63:0] data_i;
  logic        busy_o;
  logic        tick_o;
  logic [31:0] tick_count_o;
  logic        sat_o;

  int checks   = 0;
  int failures = 0;

  mtimecmp_reloader dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_en_i     (cfg_en_i),
    .period_i     (period_i),
    .mti_i        (mti_i),
    .en_o         (en_o),
    .addr_o       (addr_o),
    .we_o         (we_o),
    .data_o       (data_o),
    .data_i       (data_i),
    .busy_o       (busy_o),
    .tick_o       (tick_o),
    .tick_count_o (tick_count_o),
    .sat_o        (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the read strobe, then checks read, wait, write, guard and idle.
  task automatic seq(input string tag, input logic [3:0] exp_addr, input logic [63:0] exp_data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (en_o === 1'b1) seen = 1'b1;
    end
    chk({tag, "_rd_seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      chk({tag, "_rd_addr"}, {60'd0, addr_o}, {60'd0, exp_addr});
      chk({tag, "_rd_we"}, {56'd0, we_o}, 64'h00);
      chk({tag, "_rd_busy"}, {63'd0, busy_o}, 64'd1);
      step();
      chk({tag, "_wait_en"}, {63'd0, en_o}, 64'd0);
      step();
      chk({tag, "_wr_en"}, {63'd0, en_o}, 64'd1);
      chk({tag, "_wr_we"}, {56'd0, we_o}, 64'hFF);
      chk({tag, "_wr_addr"}, {60'd0, addr_o}, 64'h8);
      chk({tag, "_wr_data"}, data_o, exp_data);
      chk({tag, "_wr_tick"}, {63'd0, tick_o}, 64'd1);
      step();
      chk({tag, "_g1_en"}, {63'd0, en_o}, 64'd0);
      chk({tag, "_g1_tick"}, {63'd0, tick_o}, 64'd0);
      chk({tag, "_g1_busy"}, {63'd0, busy_o}, 64'd1);
      step();
      chk({tag, "_g2_en"}, {63'd0, en_o}, 64'd0);
      step();
      chk({tag, "_idle_en"}, {63'd0, en_o}, 64'd0);
      chk({tag, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    cfg_en_i = 1'b0;
    period_i = 64'd0;
    mti_i    = 1'b0;
    data_i   = 64'd0;
    step();
    step();
    chk("rst_en", {63'd0, en_o}, 64'd0);
    chk("rst_we", {56'd0, we_o}, 64'd0);
    chk("rst_addr", {60'd0, addr_o}, 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_tick", {63'd0, tick_o}, 64'd0);
    chk("rst_cnt", {32'd0, tick_count_o}, 64'd0);
    chk("rst_sat", {63'd0, sat_o}, 64'd0);
    reset = 1'b0;
    step();

    // Arm: mtime=100, period=50 -> 150
    period_i = 64'd50;
    data_i   = 64'd100;
    cfg_en_i = 1'b1;
    seq("arm", 4'h0, 64'd150);
    chk("arm_cnt", {32'd0, tick_count_o}, 64'd1);

    // Reload from 150 with mti held high through the guard window
    data_i = 64'd150;
    mti_i  = 1'b1;
    seq("rld1", 4'h8, 64'd200);
    chk("rld1_cnt", {32'd0, tick_count_o}, 64'd2);
    // mti still high: exactly one more reload, then drop it
    data_i = 64'd200;
    seq("rld2", 4'h8, 64'd250);
    mti_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rld2_quiet_en", {63'd0, en_o}, 64'd0);
    end
    chk("rld2_cnt", {32'd0, tick_count_o}, 64'd3);

    // Zero period treated as 1
    data_i   = 64'd150;
    period_i = 64'd0;
    mti_i    = 1'b1;
    seq("p0", 4'h8, 64'd151);
    mti_i = 1'b0;
    chk("p0_sat", {63'd0, sat_o}, 64'd0);

    // Saturation, then sticky across a normal reload
    data_i   = 64'hFFFF_FFFF_FFFF_FFF0;
    period_i = 64'd32;
    mti_i    = 1'b1;
    seq("sat", 4'h8, 64'hFFFF_FFFF_FFFF_FFFF);
    mti_i = 1'b0;
    chk("sat_set", {63'd0, sat_o}, 64'd1);
    data_i   = 64'd10;
    period_i = 64'd5;
    mti_i    = 1'b1;
    seq("sat2", 4'h8, 64'd15);
    mti_i = 1'b0;
    chk("sat_sticky", {63'd0, sat_o}, 64'd1);
    chk("sat2_cnt", {32'd0, tick_count_o}, 64'd6);

    // Tick counter wrap
    force dut.tick_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.tick_count_q;
    chk("wrap_pre", {32'd0, tick_count_o}, 64'hFFFF_FFFF);
    mti_i = 1'b1;
    seq("wrap", 4'h8, 64'd15);
    mti_i = 1'b0;
    chk("wrap_cnt", {32'd0, tick_count_o}, 64'd0);

    // Enable falling mid-sequence does not abort
    cfg_en_i = 1'b0;
    step();
    data_i   = 64'd100;
    period_i = 64'd50;
    cfg_en_i = 1'b1;
    step();
    chk("fall_rd_en", {63'd0, en_o}, 64'd1);
    chk("fall_rd_addr", {60'd0, addr_o}, 64'h0);
    cfg_en_i = 1'b0;
    step();
    step();
    chk("fall_wr_en", {63'd0, en_o}, 64'd1);
    chk("fall_wr_data", data_o, 64'd150);
    for (int i = 0; i < 5; i++) step();
    chk("fall_idle_busy", {63'd0, busy_o}, 64'd0);
    chk("fall_cnt", {32'd0, tick_count_o}, 64'd1);

    // Reset while in RD_WAIT
    data_i   = 64'd1000;
    cfg_en_i = 1'b1;
    step();
    chk("rw_rd_en", {63'd0, en_o}, 64'd1);
    step();
    reset = 1'b1;
    step();
    chk("rw_en", {63'd0, en_o}, 64'd0);
    chk("rw_we", {56'd0, we_o}, 64'd0);
    chk("rw_addr", {60'd0, addr_o}, 64'd0);
    chk("rw_data", data_o, 64'd0);
    chk("rw_busy", {63'd0, busy_o}, 64'd0);
    chk("rw_tick", {63'd0, tick_o}, 64'd0);
    chk("rw_cnt", {32'd0, tick_count_o}, 64'd0);
    chk("rw_sat", {63'd0, sat_o}, 64'd0);
    reset    = 1'b0;
    cfg_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_quiet_en", {63'd0, en_o}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mtimecmp_reloader

`default_nettype wire

// File: doc/mtimecmp_reloader.md
MTIMECMP_RELOADER -- requirements
Module: mtimecmp_reloader

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: cfg_en_i  input  1  reload engine enable, level.
REQ-004 SHALL have port: period_i  input  64  tick period in mtime counts, sampled at each sum computation.
REQ-005 SHALL have port: mti_i  input  1  registered timer-interrupt level from the RTC responder.
REQ-006 SHALL have port: en_o  output  1  RTC access strobe, one cycle per access.
REQ-007 SHALL have port: addr_o  output  4  RTC byte address: 4'h0 = mtime, 4'h8 = mtimecmp.
REQ-008 SHALL have port: we_o  output  8  byte write enables; 8'h00 = read, 8'hFF = full 64-bit write.
REQ-009 SHALL have port: data_o  output  64  write data to the RTC.
REQ-010 SHALL have port: data_i  input  64  RTC read data, valid the cycle after a read strobe.
REQ-011 SHALL have port: busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port: tick_o  output  1  one-cycle pulse on every mtimecmp write.
REQ-013 SHALL have port: tick_count_o  output  32  count of mtimecmp writes, wraps 32'hFFFF_FFFF -> 0.
REQ-014 SHALL have port: sat_o  output  1  sticky flag, set when a computed compare value saturated.

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR, GUARD.
REQ-016 SHALL drive all bus outputs and busy_o from registered state only (Moore), with en_o=0, we_o=0 outside RD_REQ/WR.
REQ-017 IDLE: on cfg_en_i rising (registered previous value 0, current 1) SHALL go to RD_REQ with source = mtime (arm).
REQ-018 IDLE: on cfg_en_i=1 and mti_i=1 with no rising edge SHALL go to RD_REQ with source = mtimecmp (reload); rising edge takes priority.
REQ-019 RD_REQ (1 cycle): en_o=1, we_o=8'h00, addr_o = 4'h0 for arm or 4'h8 for reload; next state RD_WAIT.
REQ-020 RD_WAIT (1 cycle): SHALL register next_q = data_i + eff_period, eff_period = 1 when period_i = 0, else period_i; next state WR.
REQ-021 Sum SHALL be 65-bit internally; on carry, next_q = 64'hFFFF_FFFF_FFFF_FFFF and sat_o SHALL be set.
REQ-022 WR (1 cycle): en_o=1, we_o=8'hFF, addr_o=4'h8, data_o=next_q, tick_o=1, tick_count_o increments; next state GUARD.
REQ-023 GUARD SHALL last exactly 2 cycles, ignoring mti_i, to cover the RTC compare-plus-register latency, then return to IDLE.
REQ-024 cfg_en_i falling mid-sequence SHALL NOT abort; the sequence completes, then the FSM stays in IDLE.
REQ-025 data_o SHALL hold next_q at all times; it is qualified only by en_o and we_o.
REQ-026 Minimum spacing between two mtimecmp writes SHALL be 5 cycles.

Reset
REQ-027 On reset=1 at a clock edge: state=IDLE, en_o=0, we_o=0, addr_o=0, next_q=0, data_o=0, busy_o=0, tick_o=0, tick_count_o=0, sat_o=0, registered cfg_en=0.
REQ-028 Reset mid-sequence SHALL abandon the sequence without issuing any further access; sat_o is cleared only by reset.

Structure
REQ-029 State enum and constants RTC_ADDR_MTIME=4'h0 and RTC_ADDR_MTIMECMP=4'h8 SHALL live in the shared RS5_pkg.
REQ-030 Single module, no sub-modules; the 65-bit saturating add is inline.

Verification
REQ-031 Arm: mtime=100, period_i=50, cfg_en_i 0->1 -> read at addr 0, then write 150 to addr 8, tick_count_o=1.
REQ-032 Reload: mtimecmp=150, mti_i rises -> read at addr 8, write 200 exactly 2 cycles after the read strobe, tick_o pulses once.
REQ-033 Persistent mti_i=1 during GUARD -> no second access within 5 cycles; after GUARD, exactly one new reload.
REQ-034 Saturation: mtimecmp=64'hFFFF_FFFF_FFFF_FFF0, period_i=32 -> write of all-ones, sat_o=1 and stays 1.
REQ-035 period_i=0 during reload from 150 -> write 151; tick_count_o at 32'hFFFF_FFFF then one write -> 0.
REQ-036 reset asserted in RD_WAIT -> no WR strobe, all outputs at reset values on the next cycle.
